// File: rtl/memory_access_block_pkg.sv
// Shared definitions for the MEM stage: data word, register address width,
// pipeline control encodings and the memory access FSM state type.
package memory_access_block_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef logic [WORD_WIDTH-1:0] word;
  typedef logic [ADDR_WIDTH-1:0] reg_addr;

  typedef enum logic {NO_MEM_READ  = 1'b0, MEM_READ  = 1'b1} mem_read_signal;
  typedef enum logic {NO_MEM_WRITE = 1'b0, MEM_WRITE = 1'b1} mem_write_signal;
  typedef enum logic {NO_REG_WRITE = 1'b0, REG_WRITE = 1'b1} reg_file_write_sig;
  typedef enum logic {ALU_RESULT   = 1'b0, MEM_RESULT = 1'b1} reg_file_data_source;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} mem_fsm_state;

endpackage

// File: rtl/memory_access_block_if.sv
// Data memory request/response bus.
//   master: drives dmem_req_o/we/addr/wdata, receives dmem_ack_i/dmem_rdata_i
//   slave : the data memory side
interface memory_access_block_if;
  import memory_access_block_pkg::*;

  logic dmem_req_o;
  logic dmem_we_o;
  word  dmem_addr_o;
  word  dmem_wdata_o;
  logic dmem_ack_i;
  word  dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/memory_access_block_mem_wb.sv
// MEM/WB pipeline register. Loads every cycle; load_bubble forces an empty
// slot (not valid, no register write).
//   clk_i, reset_i       : clock, synchronous active-high reset
//   load_bubble          : insert a bubble instead of the next_* values
//   next_*               : values captured on the next edge
//   valid/write_en/dest/data : registered MEM/WB outputs
module memory_writeback_register
  import memory_access_block_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_bubble,
  input  logic              next_valid,
  input  reg_file_write_sig next_write_en,
  input  reg_addr           next_dest,
  input  word               next_data,
  output logic              valid,
  output reg_file_write_sig write_en,
  output reg_addr           dest,
  output word               data
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid    <= 1'b0;
      write_en <= NO_REG_WRITE;
      dest     <= '0;
      data     <= '0;
    end else if (load_bubble) begin
      valid    <= 1'b0;
      write_en <= NO_REG_WRITE;
      dest     <= next_dest;
      data     <= next_data;
    end else begin
      valid    <= next_valid;
      write_en <= next_write_en;
      dest     <= next_dest;
      data     <= next_data;
    end
  end

endmodule

// File: rtl/memory_access_block.sv
// MEM pipeline stage: issues data memory accesses, stalls the front of the
// pipe while waiting for the ack, aborts on timeout, and feeds MEM/WB.
//   clk_i, reset_i            : clock, synchronous active-high reset
//   is_valid_i .. reg_2_data_i: EX/MEM entry (held by the pipe while stalled)
//   dmem                      : data memory bus (master side)
//   stall_o                   : freeze IF/ID/EX, hold EX/MEM
//   error_o                   : sticky ack-timeout flag, cleared by reset only
//   *_MEM_o                   : combinational forwarding taps
//   is_valid_o .. reg_data_o  : MEM/WB register outputs
//
// state  | meaning
// IDLE   | no access outstanding; non-memory ops pass through in one cycle
// ACCESS | request on the bus, waiting for ack or timeout
module memory_access_block
  import memory_access_block_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  is_valid_i,
  input  mem_read_signal        mem_read_en_i,
  input  mem_write_signal       mem_write_en_i,
  input  reg_file_write_sig     reg_file_write_en_i,
  input  reg_file_data_source   reg_file_data_source_i,
  input  reg_addr               reg_dest_addr_i,
  input  word                   alu_result_i,
  input  word                   reg_2_data_i,
  memory_access_block_if.master dmem,
  output logic                  stall_o,
  output logic                  error_o,
  output reg_file_write_sig     reg_write_en_MEM_o,
  output reg_addr               reg_dest_MEM_o,
  output word                   reg_data_MEM_o,
  output logic                  is_valid_o,
  output reg_file_write_sig     reg_file_write_en_o,
  output reg_addr               reg_dest_addr_o,
  output word                   reg_data_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  mem_fsm_state state;
  logic [CW-1:0] wait_cnt;

  logic is_store, is_load, mem_op, at_limit, timeout_abort;

  // Write wins when both enables are set, so such an op is never a load.
  assign is_store = (mem_write_en_i == MEM_WRITE);
  assign is_load  = (mem_read_en_i == MEM_READ) && !is_store;
  assign mem_op   = is_valid_i && (is_store || is_load);

  // wait_cnt holds the index of the current ACCESS cycle (1-based).
  assign at_limit      = (state == ACCESS) && (wait_cnt == CW'(ACK_TIMEOUT));
  assign timeout_abort = at_limit && !dmem.dmem_ack_i;

  always_comb begin
    stall_o = 1'b0;
    if (state == IDLE) stall_o = mem_op;
    else               stall_o = !(dmem.dmem_ack_i || at_limit);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      dmem.dmem_req_o   <= 1'b0;
      dmem.dmem_we_o    <= 1'b0;
      dmem.dmem_addr_o  <= '0;
      dmem.dmem_wdata_o <= '0;
      error_o           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state             <= ACCESS;
            wait_cnt          <= CW'(1);
            dmem.dmem_req_o   <= 1'b1;
            dmem.dmem_we_o    <= is_store;
            dmem.dmem_addr_o  <= alu_result_i;
            dmem.dmem_wdata_o <= reg_2_data_i;
          end
        end
        ACCESS: begin
          if (dmem.dmem_ack_i || at_limit) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            dmem.dmem_req_o <= 1'b0;
            if (!dmem.dmem_ack_i) error_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Forwarding: load results are not available yet, so loads never forward.
  assign reg_data_MEM_o     = alu_result_i;
  assign reg_dest_MEM_o     = reg_dest_addr_i;
  assign reg_write_en_MEM_o = (is_valid_i && !is_load) ? reg_file_write_en_i : NO_REG_WRITE;

  word               wb_data;
  reg_file_write_sig wb_write_en;

  assign wb_data     = (reg_file_data_source_i == MEM_RESULT && is_load) ? dmem.dmem_rdata_i
                                                                          : alu_result_i;
  assign wb_write_en = is_valid_i ? reg_file_write_en_i : NO_REG_WRITE;

  memory_writeback_register u_mem_wb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .load_bubble   (stall_o || timeout_abort),
    .next_valid    (is_valid_i),
    .next_write_en (wb_write_en),
    .next_dest     (reg_dest_addr_i),
    .next_data     (wb_data),
    .valid         (is_valid_o),
    .write_en      (reg_file_write_en_o),
    .dest          (reg_dest_addr_o),
    .data          (reg_data_o)
  );

endmodule

// File: tb/tb_memory_access_block.sv
module tb_memory_access_block;
  import memory_access_block_pkg::*;

  localparam int TO = 4;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                is_valid_i;
  mem_read_signal      mem_read_en_i;
  mem_write_signal     mem_write_en_i;
  reg_file_write_sig   reg_file_write_en_i;
  reg_file_data_source reg_file_data_source_i;
  reg_addr             reg_dest_addr_i;
  word                 alu_result_i;
  word                 reg_2_data_i;
  logic                stall_o, error_o, is_valid_o;
  reg_file_write_sig   reg_write_en_MEM_o, reg_file_write_en_o;
  reg_addr             reg_dest_MEM_o, reg_dest_addr_o;
  word                 reg_data_MEM_o, reg_data_o;

  memory_access_block_if dmem ();

  memory_access_block #(.ACK_TIMEOUT(TO)) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .is_valid_i             (is_valid_i),
    .mem_read_en_i          (mem_read_en_i),
    .mem_write_en_i         (mem_write_en_i),
    .reg_file_write_en_i    (reg_file_write_en_i),
    .reg_file_data_source_i (reg_file_data_source_i),
    .reg_dest_addr_i        (reg_dest_addr_i),
    .alu_result_i           (alu_result_i),
    .reg_2_data_i           (reg_2_data_i),
    .dmem                   (dmem),
    .stall_o                (stall_o),
    .error_o                (error_o),
    .reg_write_en_MEM_o     (reg_write_en_MEM_o),
    .reg_dest_MEM_o         (reg_dest_MEM_o),
    .reg_data_MEM_o         (reg_data_MEM_o),
    .is_valid_o             (is_valid_o),
    .reg_file_write_en_o    (reg_file_write_en_o),
    .reg_dest_addr_o        (reg_dest_addr_o),
    .reg_data_o             (reg_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    reg_addr           dest;
    word               data;
    reg_file_write_sig wen;
  } sb_entry;

  sb_entry sb_q[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Each valid MEM/WB slot must match the oldest expected writeback.
  always @(negedge clk_i) begin
    sb_entry e;
    if (!reset_i && is_valid_o) begin
      if (sb_q.size() == 0) begin
        chk_val("sb_extra_valid", 32'(reg_data_o), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk_val("sb_data", reg_data_o, e.data);
        chk_val("sb_dest", 32'(reg_dest_addr_o), 32'(e.dest));
        chk_val("sb_wen", 32'(reg_file_write_en_o), 32'(e.wen));
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input mem_read_signal rd, input mem_write_signal wr,
                       input reg_file_write_sig wen, input reg_file_data_source src,
                       input reg_addr dest, input word alu, input word d2);
    is_valid_i             = v;
    mem_read_en_i          = rd;
    mem_write_en_i         = wr;
    reg_file_write_en_i    = wen;
    reg_file_data_source_i = src;
    reg_dest_addr_i        = dest;
    alu_result_i           = alu;
    reg_2_data_i           = d2;
  endtask

  task automatic drive_idle;
    drive(1'b0, NO_MEM_READ, NO_MEM_WRITE, NO_REG_WRITE, ALU_RESULT, '0, '0, '0);
  endtask

  // One memory op. ack_at = ACCESS cycle (1-based) carrying the ack, 0 = never.
  task automatic mem_op(input string tag, input mem_read_signal rd, input mem_write_signal wr,
                        input reg_file_write_sig wen, input reg_file_data_source src,
                        input reg_addr dest, input word addr, input word wdata,
                        input word rdata, input int ack_at);
    sb_entry e;
    logic    ld;
    ld = (rd == MEM_READ) && (wr != MEM_WRITE);
    drive(1'b1, rd, wr, wen, src, dest, addr, wdata);
    #1;
    chk_val({tag, "_stall_idle"}, 32'(stall_o), 32'd1);
    chk_val({tag, "_fwd_wen"}, 32'(reg_write_en_MEM_o), ld ? 32'd0 : 32'(wen));
    if (ack_at > 0) begin
      e.dest = dest;
      e.data = (src == MEM_RESULT && ld) ? rdata : addr;
      e.wen  = wen;
      sb_q.push_back(e);
    end
    for (int c = 1; c <= TO; c++) begin
      tick();
      chk_val({tag, "_req"}, 32'(dmem.dmem_req_o), 32'd1);
      chk_val({tag, "_addr"}, dmem.dmem_addr_o, addr);
      if (c == 1) begin
        chk_val({tag, "_we"}, 32'(dmem.dmem_we_o), (wr == MEM_WRITE) ? 32'd1 : 32'd0);
        chk_val({tag, "_wdata"}, dmem.dmem_wdata_o, wdata);
      end
      if (c == ack_at) begin
        dmem.dmem_ack_i   = 1'b1;
        dmem.dmem_rdata_i = rdata;
        #1;
        chk_val({tag, "_stall_ack"}, 32'(stall_o), 32'd0);
        tick();
        dmem.dmem_ack_i   = 1'b0;
        dmem.dmem_rdata_i = '0;
        drive_idle();
        chk_val({tag, "_req_drop"}, 32'(dmem.dmem_req_o), 32'd0);
        chk_val({tag, "_valid_out"}, 32'(is_valid_o), 32'd1);
        return;
      end
      chk_val({tag, "_stall_acc"}, 32'(stall_o), (c == TO) ? 32'd0 : 32'd1);
      if (c == TO) begin
        tick();
        drive_idle();
        chk_val({tag, "_to_req"}, 32'(dmem.dmem_req_o), 32'd0);
        chk_val({tag, "_to_err"}, 32'(error_o), 32'd1);
        chk_val({tag, "_to_bubble_v"}, 32'(is_valid_o), 32'd0);
        chk_val({tag, "_to_bubble_w"}, 32'(reg_file_write_en_o), 32'd0);
        return;
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk_val({tag, "_req"}, 32'(dmem.dmem_req_o), 32'd0);
    chk_val({tag, "_we"}, 32'(dmem.dmem_we_o), 32'd0);
    chk_val({tag, "_addr"}, dmem.dmem_addr_o, 32'd0);
    chk_val({tag, "_wdata"}, dmem.dmem_wdata_o, 32'd0);
    chk_val({tag, "_err"}, 32'(error_o), 32'd0);
    chk_val({tag, "_valid"}, 32'(is_valid_o), 32'd0);
    chk_val({tag, "_wen"}, 32'(reg_file_write_en_o), 32'd0);
    chk_val({tag, "_dest"}, 32'(reg_dest_addr_o), 32'd0);
    chk_val({tag, "_data"}, reg_data_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sb_entry e;
    reset_i = 1'b1;
    dmem.dmem_ack_i   = 1'b0;
    dmem.dmem_rdata_i = '0;
    drive_idle();
    tick();
    tick();
    reset_i = 1'b0;
    chk_reset_state("rst");
    chk_val("rst_stall", 32'(stall_o), 32'd0);

    // ALU op, dest r3, 0x42
    drive(1'b1, NO_MEM_READ, NO_MEM_WRITE, REG_WRITE, ALU_RESULT, 5'd3, 32'h42, 32'h0);
    #1;
    chk_val("alu_stall", 32'(stall_o), 32'd0);
    chk_val("alu_fwd_wen", 32'(reg_write_en_MEM_o), 32'd1);
    chk_val("alu_fwd_dest", 32'(reg_dest_MEM_o), 32'd3);
    chk_val("alu_fwd_data", reg_data_MEM_o, 32'h42);
    e.dest = 5'd3; e.data = 32'h42; e.wen = REG_WRITE;
    sb_q.push_back(e);
    tick();
    drive_idle();
    chk_val("alu_valid", 32'(is_valid_o), 32'd1);
    chk_val("alu_req", 32'(dmem.dmem_req_o), 32'd0);
    tick();

    // back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      e.dest = reg_addr'(i + 7);
      e.data = $urandom;
      e.wen  = REG_WRITE;
      drive(1'b1, NO_MEM_READ, NO_MEM_WRITE, REG_WRITE, ALU_RESULT, e.dest, e.data, 32'h0);
      sb_q.push_back(e);
      #1;
      chk_val("b2b_stall", 32'(stall_o), 32'd0);
      tick();
    end
    drive_idle();
    tick();

    // invalid entry with load and reg-write enables: no request, no stall, gated wen
    drive(1'b0, MEM_READ, NO_MEM_WRITE, REG_WRITE, MEM_RESULT, 5'd9, 32'h300, 32'h0);
    #1;
    chk_val("inv_stall", 32'(stall_o), 32'd0);
    chk_val("inv_fwd_wen", 32'(reg_write_en_MEM_o), 32'd0);
    tick();
    drive_idle();
    chk_val("inv_req", 32'(dmem.dmem_req_o), 32'd0);
    chk_val("inv_valid", 32'(is_valid_o), 32'd0);
    chk_val("inv_wen", 32'(reg_file_write_en_o), 32'd0);

    mem_op("load", MEM_READ, NO_MEM_WRITE, REG_WRITE, MEM_RESULT, 5'd5, 32'h100, 32'h0,
           32'hDEAD_BEEF, 3);
    mem_op("store", NO_MEM_READ, MEM_WRITE, NO_REG_WRITE, ALU_RESULT, 5'd0, 32'h20, 32'h1234,
           32'h0, 1);
    mem_op("rdwr", MEM_READ, MEM_WRITE, REG_WRITE, MEM_RESULT, 5'd6, 32'h44, 32'h77,
           32'h0BAD_0BAD, 2);
    mem_op("ack_at_to", MEM_READ, NO_MEM_WRITE, REG_WRITE, MEM_RESULT, 5'd10, 32'h200, 32'h0,
           32'hCAFE_F00D, TO);
    chk_val("ack_at_to_err", 32'(error_o), 32'd0);
    mem_op("timeout", MEM_READ, NO_MEM_WRITE, REG_WRITE, MEM_RESULT, 5'd11, 32'h400, 32'h0,
           32'h1111_2222, 0);

    // ack in IDLE is ignored; error stays sticky
    dmem.dmem_ack_i = 1'b1;
    tick();
    dmem.dmem_ack_i = 1'b0;
    chk_val("idle_ack_req", 32'(dmem.dmem_req_o), 32'd0);
    chk_val("idle_ack_valid", 32'(is_valid_o), 32'd0);
    chk_val("err_sticky", 32'(error_o), 32'd1);

    // reset in the 2nd ACCESS cycle, ack the cycle after
    drive(1'b1, MEM_READ, NO_MEM_WRITE, REG_WRITE, MEM_RESULT, 5'd12, 32'h500, 32'h0);
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    drive_idle();
    dmem.dmem_ack_i   = 1'b1;
    dmem.dmem_rdata_i = 32'h5555_5555;
    chk_reset_state("racc");
    #1;
    chk_val("racc_stall", 32'(stall_o), 32'd0);
    tick();
    dmem.dmem_ack_i   = 1'b0;
    dmem.dmem_rdata_i = '0;
    chk_val("racc_post_req", 32'(dmem.dmem_req_o), 32'd0);
    chk_val("racc_post_valid", 32'(is_valid_o), 32'd0);
    chk_val("racc_post_err", 32'(error_o), 32'd0);
    tick();

    chk_val("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
